// File: rtl/param_lifo_pkg.sv
// Shared definitions for the parameterised LIFO.
//   DEFAULT_DATA_W / DEFAULT_DEPTH : default word width and number of entries
//   cnt_w()                        : width of an occupancy counter spanning 0..depth
//   op_e                           : per-cycle operation chosen from we/re and occupancy
package param_lifo_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_DEPTH  = 16;

    // An occupancy of exactly `depth` must be representable, hence depth+1.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_PUSH,      // push into a non-full stack
        OP_POP,       // pop from a non-empty stack
        OP_SWAP,      // we=re=1, not empty: read top, overwrite top
        OP_PUSH_UNF,  // we=re=1 while empty: push, flag underflow
        OP_OVF,       // push refused, stack full
        OP_UNF        // pop refused, stack empty
    } op_e;

endpackage

// File: rtl/param_lifo_mem.sv
// Storage array for param_lifo: DEPTH x DATA_W, no reset.
//   clk     : write clock
//   wr_en   : write strobe, wr_data stored at wr_addr on the rising edge
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address (asynchronous read)
//   rd_data : word at rd_addr
module lifo_mem
    import param_lifo_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/param_lifo.sv
// Parameterised LIFO (stack) with registered pop data and sticky error flags.
//   clk, resetn   : clock, asynchronous active-low reset
//   we, re        : push / pop requests; both together pop the top and replace it
//   datain        : push data
//   clr_err       : synchronous clear of overflow/underflow
//   dataout       : last popped word (held when no pop succeeds)
//   full, empty   : count == DEPTH / count == 0
//   almost_full   : count >= AF_LEVEL
//   count         : current occupancy 0..DEPTH
//   overflow      : sticky, push attempted while full
//   underflow     : sticky, pop attempted while empty
module param_lifo
    import param_lifo_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      we,
    input  logic                      re,
    input  logic [DATA_W-1:0]         datain,
    input  logic                      clr_err,
    output logic [DATA_W-1:0]         dataout,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int CW = cnt_w(DEPTH);
    localparam int AW = $clog2(DEPTH);

    op_e               op;
    logic [AW-1:0]     top_addr;
    logic [AW-1:0]     wr_addr;
    logic              mem_we;
    logic [DATA_W-1:0] top_data;

    assign full        = (count == CW'(DEPTH));
    assign empty       = (count == '0);
    assign almost_full = (count >= CW'(AF_LEVEL));

    always_comb begin
        op = OP_IDLE;
        unique case ({we, re})
            2'b10:   op = full  ? OP_OVF      : OP_PUSH;
            2'b01:   op = empty ? OP_UNF      : OP_POP;
            2'b11:   op = empty ? OP_PUSH_UNF : OP_SWAP;
            default: op = OP_IDLE;
        endcase
    end

    // top_addr is only meaningful when count > 0; at count == 0 it wraps
    // harmlessly since nothing reads it then.
    assign top_addr = AW'(count - CW'(1));
    // A plain push lands one above the top; count < DEPTH so it fits in AW bits.
    assign wr_addr  = (op == OP_SWAP) ? top_addr : AW'(count);
    assign mem_we   = (op == OP_PUSH) || (op == OP_PUSH_UNF) || (op == OP_SWAP);

    lifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_addr (wr_addr),
        .wr_data (datain),
        .rd_addr (top_addr),
        .rd_data (top_data)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count     <= '0;
            dataout   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            unique case (op)
                OP_PUSH, OP_PUSH_UNF: count <= count + CW'(1);
                OP_POP: begin
                    count   <= count - CW'(1);
                    dataout <= top_data;
                end
                OP_SWAP: dataout <= top_data;
                default: ;
            endcase
            // A fresh error in the same cycle as clr_err keeps the flag set.
            overflow  <= (op == OP_OVF) || (overflow && !clr_err);
            underflow <= (op == OP_UNF) || (op == OP_PUSH_UNF) || (underflow && !clr_err);
        end
    end

endmodule

// File: tb/tb_param_lifo.sv
module tb_param_lifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 14;

    logic          clk = 1'b0;
    logic          resetn;
    logic          we, re, clr_err;
    logic [DW-1:0] datain;
    logic [DW-1:0] dataout;
    logic          full, empty, almost_full, overflow, underflow;
    logic [4:0]    count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the stack is a queue whose back is the top.
    logic [DW-1:0] stk [$];
    logic [DW-1:0] m_dout;
    bit            m_ovf, m_unf;

    param_lifo #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .we          (we),
        .re          (re),
        .datain      (datain),
        .clr_err     (clr_err),
        .dataout     (dataout),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        stk.delete();
        m_dout = '0;
        m_ovf  = 0;
        m_unf  = 0;
    endtask

    task automatic model_step(input bit w, input bit r, input logic [DW-1:0] d, input bit c);
        bit new_o = 0;
        bit new_u = 0;
        if (w && r) begin
            if (stk.size() > 0) begin
                m_dout = stk[stk.size()-1];
                stk[stk.size()-1] = d;
            end else begin
                stk.push_back(d);
                new_u = 1;
            end
        end else if (w) begin
            if (stk.size() < DEPTH) stk.push_back(d);
            else new_o = 1;
        end else if (r) begin
            if (stk.size() > 0) m_dout = stk.pop_back();
            else new_u = 1;
        end
        m_ovf = new_o || (m_ovf && !c);
        m_unf = new_u || (m_unf && !c);
    endtask

    // One clock cycle of stimulus; returns 1 time unit after the edge.
    task automatic cycle(input bit w, input bit r, input logic [DW-1:0] d, input bit c);
        we = w; re = r; datain = d; clr_err = c;
        model_step(w, r, d, c);
        @(posedge clk);
        #1;
        we = 0; re = 0; clr_err = 0;
    endtask

    task automatic test_reset();
        resetn = 0; we = 0; re = 0; clr_err = 0; datain = '0;
        model_reset();
        #12;
        n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_tests++; if (empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0) begin
            n_fail++; $display("FAIL reset_status got e=%b f=%b af=%b want 1 0 0", empty, full, almost_full); end
        n_tests++; if (dataout !== 8'h00 || overflow !== 1'b0 || underflow !== 1'b0) begin
            n_fail++; $display("FAIL reset_regs got dout=%h ovf=%b unf=%b want 00 0 0", dataout, overflow, underflow); end
        @(negedge clk);
        resetn = 1;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1, 0, 8'(i), 0);
            n_tests++; if (count !== 5'(i)) begin n_fail++; $display("FAIL fill_count got %0d want %0d", count, i); end
            n_tests++; if (almost_full !== (i >= AF)) begin
                n_fail++; $display("FAIL fill_af at count %0d got %b want %b", i, almost_full, (i >= AF)); end
            n_tests++; if (full !== (i == DEPTH)) begin
                n_fail++; $display("FAIL fill_full at count %0d got %b want %b", i, full, (i == DEPTH)); end
        end
        n_tests++; if (overflow !== 1'b0 || empty !== 1'b0) begin
            n_fail++; $display("FAIL fill_flags got ovf=%b empty=%b want 0 0", overflow, empty); end
    endtask

    task automatic test_overflow();
        cycle(1, 0, 8'hAA, 0);
        n_tests++; if (count !== 5'd16) begin n_fail++; $display("FAIL ovf_count got %0d want 16", count); end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", overflow); end
        cycle(0, 1, 8'h00, 0);
        n_tests++; if (dataout !== 8'h10) begin n_fail++; $display("FAIL ovf_pop got %h want 10", dataout); end
        n_tests++; if (count !== 5'd15 || full !== 1'b0) begin
            n_fail++; $display("FAIL ovf_after_pop got count=%0d full=%b want 15 0", count, full); end
        cycle(0, 0, 8'h00, 1);
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0", overflow); end
    endtask

    task automatic test_drain();
        for (int i = 15; i >= 1; i--) begin
            cycle(0, 1, 8'h00, 0);
            n_tests++; if (dataout !== 8'(i)) begin n_fail++; $display("FAIL drain_data got %h want %h", dataout, 8'(i)); end
        end
        n_tests++; if (empty !== 1'b1 || count !== 5'd0) begin
            n_fail++; $display("FAIL drain_empty got empty=%b count=%0d want 1 0", empty, count); end
    endtask

    task automatic test_underflow();
        cycle(0, 1, 8'h00, 0);
        n_tests++; if (dataout !== 8'h01) begin n_fail++; $display("FAIL unf_hold got %h want 01", dataout); end
        n_tests++; if (underflow !== 1'b1 || count !== 5'd0) begin
            n_fail++; $display("FAIL unf_flag got unf=%b count=%0d want 1 0", underflow, count); end
        cycle(0, 0, 8'h00, 1);
        n_tests++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL unf_clear got %b want 0", underflow); end
        // Clear and a fresh error on the same edge: the error wins.
        cycle(0, 1, 8'h00, 1);
        n_tests++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_clr_race got %b want 1", underflow); end
        cycle(0, 0, 8'h00, 1);
    endtask

    task automatic test_swap();
        cycle(1, 0, 8'h11, 0);
        cycle(1, 0, 8'h22, 0);
        cycle(1, 1, 8'h33, 0);
        n_tests++; if (dataout !== 8'h22) begin n_fail++; $display("FAIL swap_data got %h want 22", dataout); end
        n_tests++; if (count !== 5'd2 || underflow !== 1'b0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL swap_state got count=%0d unf=%b ovf=%b want 2 0 0", count, underflow, overflow); end
        cycle(0, 1, 8'h00, 0);
        n_tests++; if (dataout !== 8'h33) begin n_fail++; $display("FAIL swap_pop1 got %h want 33", dataout); end
        cycle(0, 1, 8'h00, 0);
        n_tests++; if (dataout !== 8'h11 || empty !== 1'b1) begin
            n_fail++; $display("FAIL swap_pop2 got %h empty=%b want 11 1", dataout, empty); end
    endtask

    task automatic test_swap_empty();
        cycle(1, 1, 8'h44, 0);
        n_tests++; if (count !== 5'd1 || underflow !== 1'b1) begin
            n_fail++; $display("FAIL swap_empty got count=%0d unf=%b want 1 1", count, underflow); end
        n_tests++; if (dataout !== 8'h11) begin n_fail++; $display("FAIL swap_empty_hold got %h want 11", dataout); end
        cycle(0, 1, 8'h00, 1);
        n_tests++; if (dataout !== 8'h44 || underflow !== 1'b0) begin
            n_fail++; $display("FAIL swap_empty_pop got %h unf=%b want 44 0", dataout, underflow); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 6; i++) cycle(1, 0, 8'(8'h51 + i), 0);
        cycle(0, 1, 8'h00, 0);
        n_tests++; if (count !== 5'd5 || dataout !== 8'h56) begin
            n_fail++; $display("FAIL areset_pre got count=%0d dout=%h want 5 56", count, dataout); end
        #2;
        resetn = 0;
        model_reset();
        #1;
        n_tests++; if (count !== 5'd0 || dataout !== 8'h00 || empty !== 1'b1) begin
            n_fail++; $display("FAIL areset_now got count=%0d dout=%h empty=%b want 0 00 1", count, dataout, empty); end
        @(negedge clk);
        resetn = 1;
        cycle(0, 1, 8'h00, 0);
        n_tests++; if (underflow !== 1'b1 || dataout !== 8'h00) begin
            n_fail++; $display("FAIL areset_first_pop got unf=%b dout=%h want 1 00", underflow, dataout); end
        cycle(0, 0, 8'h00, 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            int  p = ((i / 40) % 2 == 0) ? 75 : 25;
            bit  w = ($urandom_range(99) < p);
            bit  r = ($urandom_range(99) < (100 - p));
            bit  c = ($urandom_range(7) == 0);
            logic [DW-1:0] d = DW'($urandom);
            cycle(w, r, d, c);
            n_tests++; if (count !== 5'(stk.size())) begin
                n_fail++; $display("FAIL rnd_count cyc %0d got %0d want %0d", i, count, stk.size()); end
            n_tests++; if (dataout !== m_dout) begin
                n_fail++; $display("FAIL rnd_data cyc %0d got %h want %h", i, dataout, m_dout); end
            n_tests++; if (overflow !== m_ovf || underflow !== m_unf) begin
                n_fail++; $display("FAIL rnd_err cyc %0d got ovf=%b unf=%b want %b %b", i, overflow, underflow, m_ovf, m_unf); end
            n_tests++; if (full !== (stk.size() == DEPTH) || empty !== (stk.size() == 0) || almost_full !== (stk.size() >= AF)) begin
                n_fail++; $display("FAIL rnd_status cyc %0d got f=%b e=%b af=%b size %0d", i, full, empty, almost_full, stk.size()); end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_underflow();
        test_swap();
        test_swap_empty();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
